// File: rtl/led_event_scheduler.sv
// Display-event arbiter between the door-lock FSM and the RGB LED driver.
// Optional error escalation to alarm: define LED_SCHED_ESCALATE_EN.
module led_event_scheduler #(
  parameter logic [27:0] TICK_DIV  = 28'd4,
  parameter logic [7:0]  OK_TICKS  = 8'd3,
`ifdef LED_SCHED_ESCALATE_EN
  parameter logic [7:0]  ESC_TICKS = 8'd4,
`endif
  parameter logic [7:0]  ERR_TICKS = 8'd2
) (
  input  logic       clk_in,
  input  logic       idle,
  input  logic       armed,
  input  logic       req_ok,
  input  logic       req_err,
  input  logic       req_alarm,
  output logic [2:0] led_rgb,
  output logic       rgb_toggle,
  output logic       busy,
  output logic [1:0] event_id
);

  // Zero-valued parameters behave as 1.
  localparam logic [27:0] DIV_M1 = (TICK_DIV  == 28'd0) ? 28'd0 : TICK_DIV  - 28'd1;
  localparam logic [7:0]  OK_M1  = (OK_TICKS  == 8'd0)  ? 8'd0  : OK_TICKS  - 8'd1;
  localparam logic [7:0]  ERR_M1 = (ERR_TICKS == 8'd0)  ? 8'd0  : ERR_TICKS - 8'd1;

  // Encoding doubles as event_id.
  typedef enum logic [1:0] {
    S_DEF   = 2'd0,
    S_OK    = 2'd1,
    S_ERR   = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] presc_q;
  logic [7:0]  tcnt_q;
  logic        pend_ok_q, pend_ok_d;
  logic        pend_err_q, pend_err_d;
  logic        tick, ev_done, restart, arb, want_ok, want_err;
  logic        esc_fire, esc_stay;

  assign tick     = (presc_q == DIV_M1);
  assign want_ok  = req_ok  | pend_ok_q;
  assign want_err = req_err | pend_err_q;

`ifdef LED_SCHED_ESCALATE_EN
  localparam logic [7:0] ESC_M1 = (ESC_TICKS == 8'd0) ? 8'd0 : ESC_TICKS - 8'd1;

  logic [1:0] err_cnt_q;
  logic       esc_hold_q;
  logic       esc_done;

  assign esc_fire = req_err && (err_cnt_q == 2'd2) && (state_q != S_ALARM);
  assign esc_done = esc_hold_q && tick && (tcnt_q == ESC_M1);
  assign esc_stay = esc_hold_q && !esc_done;

  // Counts every req_err pulse outside ALARM, absorbed ones included.
  always_ff @(posedge clk_in) begin
    if (idle) begin
      err_cnt_q  <= 2'd0;
      esc_hold_q <= 1'b0;
    end else begin
      if (esc_fire || state_q == S_ALARM) err_cnt_q <= 2'd0;
      else if (req_ok)                    err_cnt_q <= {1'b0, req_err};
      else if (req_err)                   err_cnt_q <= err_cnt_q + 2'd1;

      if (esc_fire)      esc_hold_q <= 1'b1;
      else if (esc_done) esc_hold_q <= 1'b0;
    end
  end
`else
  assign esc_fire = 1'b0;
  assign esc_stay = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    pend_ok_d  = pend_ok_q;
    pend_err_d = pend_err_q;
    restart    = 1'b0;
    arb        = 1'b0;
    unique case (state_q)
      S_OK:    ev_done = tick && (tcnt_q == OK_M1);
      S_ERR:   ev_done = tick && (tcnt_q == ERR_M1);
      default: ev_done = 1'b0;
    endcase

    if (req_alarm || esc_fire) begin
      state_d    = S_ALARM;
      pend_ok_d  = 1'b0;
      pend_err_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ALARM: if (!esc_stay) state_d = S_DEF;
        S_OK: begin
          if (ev_done) arb = 1'b1;
          else if (req_err) begin
            state_d   = S_ERR;
            pend_ok_d = req_ok;
          end else if (req_ok) restart = 1'b1;
        end
        S_ERR: begin
          if (ev_done) arb = 1'b1;
          else begin
            if (req_err) restart   = 1'b1;
            if (req_ok)  pend_ok_d = 1'b1;
          end
        end
        default: arb = 1'b1;
      endcase

      // Completion / idle arbitration: pending flags compete with new requests.
      if (arb) begin
        if (want_err) begin
          state_d    = S_ERR;
          pend_err_d = 1'b0;
          pend_ok_d  = want_ok;
        end else if (want_ok) begin
          state_d   = S_OK;
          pend_ok_d = 1'b0;
        end else begin
          state_d = S_DEF;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (idle) begin
      state_q    <= S_DEF;
      pend_ok_q  <= 1'b0;
      pend_err_q <= 1'b0;
      presc_q    <= 28'd0;
      tcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      pend_ok_q  <= pend_ok_d;
      pend_err_q <= pend_err_d;
      if (restart || arb || state_d != state_q || state_d == S_DEF) begin
        presc_q <= 28'd0;
        tcnt_q  <= 8'd0;
      end else if (tick) begin
        presc_q <= 28'd0;
        tcnt_q  <= (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
      end else begin
        presc_q <= presc_q + 28'd1;
      end
    end
  end

  // NOTE: outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_in) begin
    if (idle) begin
      led_rgb    <= 3'b000;
      rgb_toggle <= 1'b0;
      busy       <= 1'b0;
      event_id   <= 2'd0;
    end else begin
      event_id <= state_d;
      unique case (state_d)
        S_OK:    begin led_rgb <= 3'b010; rgb_toggle <= 1'b0; busy <= 1'b1; end
        S_ERR:   begin led_rgb <= 3'b011; rgb_toggle <= 1'b1; busy <= 1'b1; end
        S_ALARM: begin led_rgb <= 3'b001; rgb_toggle <= 1'b1; busy <= 1'b1; end
        default: begin
          led_rgb    <= armed ? 3'b100 : 3'b000;
          rgb_toggle <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
